// File: rtl/seq_counter_pkg.sv
// seq_counter_pkg: shared constants, preload table and index stepping for seq_counter
package seq_counter_pkg;
  localparam logic [17:0] LEGACY_SEQ = {3'd2, 3'd7, 3'd4, 3'd5, 3'd3, 3'd0};
  typedef logic [6:0] idx_t;
  typedef struct packed {
    idx_t idx;
    logic wrap;
  } step_t;
  function automatic logic [15:0] preload(input int i, input int width, input int depth, input bit legacy);
    return (legacy && i < depth) ? 16'(LEGACY_SEQ[3*(i%6) +: 3]) : 16'(i & ((1 << width) - 1));
  endfunction
  function automatic step_t step_idx(input idx_t idx, input logic dir, input idx_t depth);
    step_t s;
    s.wrap = dir ? (idx == '0) : (idx == depth - 7'd1);
    s.idx = dir ? (s.wrap ? depth - 7'd1 : idx - 7'd1) : (s.wrap ? '0 : idx + 7'd1);
    return s;
  endfunction
endpackage

// File: rtl/seq_table.sv
// seq_table: DEPTH x WIDTH code table with reset preload, one write port and write-through read
module seq_table
  import seq_counter_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 6,
  parameter bit LEGACY = 1'b1,
  parameter int IW     = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [IW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (!clear)
      for (int i = 0; i < DEPTH; i++) mem[i] <= WIDTH'(preload(i, WIDTH, DEPTH, LEGACY));
    else if (we)
      mem[waddr] <= wdata;
  assign rdata = (we && waddr == raddr) ? wdata : mem[raddr];
endmodule

// File: rtl/seq_counter.sv
// seq_counter: steps through a programmable code table forward or reverse with load, wrap and error flags
module seq_counter
  import seq_counter_pkg::*;
#(
  parameter int WIDTH  = 3,
  parameter int DEPTH  = 6,
  parameter bit LEGACY = 1'b1,
  localparam int IW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             clear,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [IW-1:0]    load_idx,
  input  logic             wr_en,
  input  logic [IW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] q,
  output logic [IW-1:0]    idx,
  output logic             wrap,
  output logic             err
);
  localparam logic [IW:0] DEPTH_L = (IW+1)'(DEPTH);
  if (LEGACY && (WIDTH < 3 || DEPTH != 6)) begin : g_bad_cfg
    $error("seq_counter: LEGACY=1 requires WIDTH>=3 and DEPTH=6");
  end
  logic             ld_bad, wr_bad, wrap_n;
  logic [IW-1:0]    idx_n;
  logic [WIDTH-1:0] rd;
  step_t            st;
  assign ld_bad = load && {1'b0, load_idx} >= DEPTH_L;
  assign wr_bad = wr_en && {1'b0, wr_addr} >= DEPTH_L;
  always_comb begin
    st = step_idx(idx_t'(idx), dir, idx_t'(DEPTH));
    idx_n = load ? (ld_bad ? idx : load_idx) : en ? IW'(st.idx) : idx;
    wrap_n = !load && en && st.wrap;
  end
  seq_table #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LEGACY(LEGACY), .IW(IW)) u_table (
    .clk(clk),
    .clear(clear),
    .we(wr_en && !wr_bad),
    .waddr(wr_addr),
    .wdata(wr_data),
    .raddr(idx_n),
    .rdata(rd)
  );
  always_ff @(posedge clk)
    if (!clear) begin
      idx  <= '0;
      q    <= WIDTH'(preload(0, WIDTH, DEPTH, LEGACY));
      wrap <= 1'b0;
      err  <= 1'b0;
    end else begin
      idx  <= idx_n;
      q    <= rd;
      wrap <= wrap_n;
      err  <= ld_bad || wr_bad;
    end
endmodule

// File: doc/seq_counter.md
# seq_counter

Parametrised synchronous sequence counter: steps through a programmable table of DEPTH codes of WIDTH bits, forward or reverse, and presents the current code on a registered output. Successor to the fixed gate-level 0→3→5→4→7→2 JK counter. Adds run-time table rewrite, direction control, index load and a wrap flag. Used wherever the design needs a non-binary state sequence, such as a stepper phase generator or a Gray/custom-code source.

## Interface
- WIDTH, 3: bits per sequence code; 1..16.
- DEPTH, 6: number of table entries; 2..64.
- LEGACY, 1: 1 preloads the table with 0,3,5,4,7,2 at reset; legal only with WIDTH≥3 and DEPTH=6, otherwise elaboration error. 0 preloads entry i with i mod 2^WIDTH.
- IW, derived: $clog2(DEPTH).

Ports:
- clk  in  1  single clock, rising edge.
- clear  in  1  reset, synchronous and active-low (clear=0 at a rising clk edge resets).
- en  in  1  advance one step this cycle.
- dir  in  1  0 = forward (idx+1), 1 = reverse (idx−1).
- load  in  1  jump to load_idx this cycle.
- load_idx  in  IW  target index for load.
- wr_en  in  1  write one table entry.
- wr_addr  in  IW  entry to write.
- wr_data  in  WIDTH  code to write.
- q  out  WIDTH  current code, registered; always equals table[idx].
- idx  out  IW  current table index, registered.
- wrap  out  1  one-cycle pulse after a step that wrapped the index.
- err  out  1  one-cycle pulse after an illegal load_idx or wr_addr (≥DEPTH).

## Operation
- Reset (clear=0): idx=0, table=preload, q=preload[0] (0 in both modes), wrap=0, err=0. Reset overrides every other input.
- Next index priority, per cycle:
  - load=1: idx_n = load_idx. If load_idx ≥ DEPTH, idx_n = idx (hold) and err=1.
  - else en=1: forward gives idx_n = (idx==DEPTH−1) ? 0 : idx+1; reverse gives idx_n = (idx==0) ? DEPTH−1 : idx−1.
  - else idx_n = idx.
- wrap=1 next cycle only for an en step that crosses DEPTH−1→0 (forward) or 0→DEPTH−1 (reverse). A load never sets wrap, even to 0.
- Table write: when wr_en=1 and wr_addr<DEPTH, table[wr_addr] ← wr_data. When wr_addr ≥ DEPTH, no write and err=1.
- q ← table_n[idx_n], where table_n includes the same-cycle write (write-through). Consequences:
  - A write to the current idx without a step updates q next cycle.
  - A write to the entry being stepped into is visible on q immediately.
- err is the OR of both illegal conditions in one cycle.
- No unused-state lockup is possible: idx is only ever assigned legal values. idx is the state; q is data.

## Timing
- All outputs registered; no combinational input→output path.
- Latency: en/load/wr at edge N → q, idx, wrap, err valid after edge N. One cycle, steps back-to-back every cycle.
- dir may change every cycle; it is sampled only when en=1 and load=0.
- Reset mid-sequence: the next edge with clear=0 forces idx=0 and restores the preload, discarding runtime writes. The first step after release moves to index 1 (forward) or DEPTH−1 (reverse).
- Simultaneous load+en: load wins and en is ignored. Simultaneous load+wr to load_idx: q shows wr_data.

## Structure
- Package seq_counter_pkg holds:
  - LEGACY_SEQ constant {0,3,5,4,7,2}.
  - function preload(i, WIDTH, DEPTH, LEGACY) returning the reset code.
  - function step_idx(idx, dir, DEPTH) returning next index and wrap.
- Sub-module seq_table holds the DEPTH×WIDTH register file: sync active-low reset to preload, one write port, one combinational read port with write-through. seq_counter contains index control, q/wrap/err registers and the bound checks.

## Test plan
- Legacy order: reset, then en=1, dir=0 for 7 cycles → q = 3,5,4,7,2,0,3. wrap=1 only on the cycle q returns to 0.
- Reverse: from reset, en=1, dir=1 for 3 cycles → q = 2,7,4; idx = 5,4,3. wrap=1 after the first step only.
- Write-through: idx=2 (q=5); wr_en, wr_addr=2, wr_data=6, en=0 → next cycle q=6. Then wr_addr=3, wr_data=1 with en=1 → q=1, idx=3.
- Load/illegal: load_idx=4 with en=1 → idx=4, q=7, wrap=0. Then load_idx=6 → idx holds at 4, err pulses one cycle. Then wr_addr=7 → err pulses and the table is unchanged.
- Reset mid-run: after writes, table[0]=5 and idx=3. clear=0 for one edge → idx=0, q=0, table restored (stepping yields 3,5,...).
- Generic: WIDTH=4, DEPTH=16, LEGACY=0. 17 forward steps → q = 1..15,0,1, with wrap exactly once.
